// File: rtl/mem_arbiter_seq.sv
// Byte-wide RAM/IO bus arbiter: round-robin between fetch and load/store, sequencing each
// granted access into per-byte bus cycles with read assembly/extension and IO write stalls.
module mem_arbiter_seq #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_grant,
  output logic        if_done,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_width,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_grant,
  output logic        ls_done,
  output logic [31:0] rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, nbytes_q, nbytes_d;
  logic [AW-1:0]   addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d, rdata_q, rdata_d;
  logic [AW-1:0]   mem_a_q, mem_a_d;
  logic [7:0]      mem_dout_q, mem_dout_d;
  logic            uns_q, uns_d, is_if_q, is_if_d, io_q, io_d, last_ls_q, last_ls_d;
  logic            wr_q, wr_d;
  logic            if_grant_q, if_grant_d, ls_grant_q, ls_grant_d;
  logic            if_done_q, if_done_d, ls_done_q, ls_done_d;

  logic            if_ok, pick_ls, acc_we;
  logic [AW-1:0]   acc_addr;
  logic [1:0]      nxt_b, lat_b;

  function automatic logic [CW-1:0] width_bytes(input logic [1:0] w);
    case (w)
      2'd0:    return CW'(1);
      2'd1:    return CW'(2);
      default: return CW'(4);
    endcase
  endfunction

  // Sign- or zero-extend a 1/2-byte result to 32 bits.
  function automatic logic [31:0] extend(input logic [31:0] v, input logic [CW-1:0] n,
                                         input logic uns);
    case (n)
      CW'(1):  return uns ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      CW'(2):  return uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    uns_d      = uns_q;
    is_if_d    = is_if_q;
    io_d       = io_q;
    last_ls_d  = last_ls_q;
    wr_d       = wr_q;
    if_grant_d = if_grant_q;
    ls_grant_d = ls_grant_q;
    if_done_d  = if_done_q;
    ls_done_d  = ls_done_q;

    // Fetch is blocked by flush; on contention the side not granted last time wins.
    if_ok    = if_req & ~flush;
    pick_ls  = ls_req & (~if_ok | ~last_ls_q);
    acc_addr = pick_ls ? ls_addr : if_addr;
    acc_we   = pick_ls & ls_we;
    nxt_b    = 2'(cnt_q + CW'(1));
    lat_b    = 2'(cnt_q - CW'(1));

    if (rdy_in) begin
      if_grant_d = 1'b0;
      ls_grant_d = 1'b0;
      if_done_d  = 1'b0;
      ls_done_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_ok | pick_ls) begin
            state_d    = acc_we ? S_WRITE : S_READ;
            cnt_d      = '0;
            addr_d     = acc_addr;
            wdata_d    = ls_wdata;
            nbytes_d   = pick_ls ? width_bytes(ls_width[1:0]) : CW'(4);
            uns_d      = pick_ls ? ls_width[2] : 1'b1;
            is_if_d    = ~pick_ls;
            io_d       = (acc_addr[17:16] == IO_SEL);
            last_ls_d  = pick_ls;
            if_grant_d = ~pick_ls;
            ls_grant_d = pick_ls;
            mem_a_d    = acc_addr;
            wr_d       = acc_we;
            mem_dout_d = acc_we ? ls_wdata[7:0] : 8'd0;
            buf_d      = '0;
          end
        end
        S_READ: begin
          if (is_if_q && flush) begin
            state_d = S_IDLE;
            mem_a_d = '0;
          end else begin
            // Byte for the address issued last cycle arrives now.
            if (cnt_q != '0) buf_d[{lat_b, 3'b000} +: 8] = mem_din;
            if (cnt_q == nbytes_q) begin
              state_d   = S_DONE;
              rdata_d   = extend(buf_d, nbytes_q, uns_q);
              if_done_d = is_if_q;
              ls_done_d = ~is_if_q;
              mem_a_d   = '0;
            end else begin
              cnt_d   = cnt_q + CW'(1);
              mem_a_d = ((cnt_q + CW'(1)) < nbytes_q) ? addr_q + AW'(cnt_q) + AW'(1) : '0;
            end
          end
        end
        S_WRITE: begin
          if (!(io_q && io_buffer_full)) begin
            if (cnt_q == nbytes_q - CW'(1)) begin
              state_d    = S_DONE;
              ls_done_d  = 1'b1;
              wr_d       = 1'b0;
              mem_a_d    = '0;
              mem_dout_d = 8'd0;
            end else begin
              cnt_d      = cnt_q + CW'(1);
              mem_a_d    = addr_q + AW'(cnt_q) + AW'(1);
              mem_dout_d = wdata_q[{nxt_b, 3'b000} +: 8];
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      rdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      uns_q      <= 1'b0;
      is_if_q    <= 1'b0;
      io_q       <= 1'b0;
      last_ls_q  <= 1'b0;
      wr_q       <= 1'b0;
      if_grant_q <= 1'b0;
      ls_grant_q <= 1'b0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      rdata_q    <= rdata_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      uns_q      <= uns_d;
      is_if_q    <= is_if_d;
      io_q       <= io_d;
      last_ls_q  <= last_ls_d;
      wr_q       <= wr_d;
      if_grant_q <= if_grant_d;
      ls_grant_q <= ls_grant_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
    end
  end

  // Write strobe drops immediately on freeze or a full UART buffer at an IO address.
  assign mem_wr   = wr_q & rdy_in & ~(io_q & io_buffer_full);
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign if_grant = if_grant_q;
  assign ls_grant = ls_grant_q;
  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_arbiter_seq.sv
// Bench for mem_arbiter_seq: directed scenarios plus random transactions checked against
// a transaction-level model of bus timing, byte order and extension.
module tb_mem_arbiter_seq;

  logic        clk_in, rst_in, rdy_in, io_buffer_full, flush;
  logic        if_req, ls_req, ls_we, mem_wr;
  logic        if_grant, if_done, ls_grant, ls_done;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a, if_addr, ls_addr, ls_wdata, rdata;
  logic [2:0]  ls_width;

  logic [7:0]  ram [256];
  int          n_cmp, n_err;
  logic        exp_last_ls;
  logic [31:0] exp_rdata;

  mem_arbiter_seq #(.IO_SEL(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_width(ls_width), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_grant(ls_grant), .ls_done(ls_done), .rdata(rdata)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Memory answers one cycle after the address.
  always @(posedge clk_in) mem_din <= ram[mem_a[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int nbytes_of(input bit is_if, input logic [2:0] w);
    if (is_if || w[1]) return 4;
    return w[0] ? 2 : 1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n, input bit uns);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(ram[8'(a + 32'(k))]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // One transaction from an idle bus; fm/zm mark cycles with io_buffer_full high / rdy_in low.
  task automatic xact(input bit is_if, input bit we, input logic [2:0] w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [63:0] fm, input logic [63:0] zm,
                      input string tag);
    logic [31:0] ra [64];
    logic        rw [64];
    logic [7:0]  rd [64];
    logic [31:0] rdat, exp;
    int          g, d, n, t, k, bad;
    bit          io, blocked;
    n = nbytes_of(is_if, w);
    io = !is_if && (a[17:16] == 2'b11);
    g = -1; d = -1; bad = 0; rdat = '0;
    if (is_if) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      ls_req = 1'b1; ls_we = we; ls_width = w; ls_addr = a; ls_wdata = wd;
    end
    io_buffer_full = fm[0];
    rdy_in = !zm[0];
    for (int c = 0; c < 64 && d < 0; c++) begin
      if (c > 0) begin
        next_cycle();
        if_req = 1'b0; ls_req = 1'b0;
        io_buffer_full = fm[c];
        rdy_in = !zm[c];
      end
      @(negedge clk_in);
      ra[c] = mem_a; rw[c] = mem_wr; rd[c] = mem_dout;
      if ((is_if ? if_grant : ls_grant) && g < 0) g = c;
      if (is_if ? (ls_grant | ls_done) : (if_grant | if_done)) bad = 1;
      if (is_if ? if_done : ls_done) begin
        d = c; rdat = rdata;
      end
    end
    next_cycle();
    io_buffer_full = 1'b0; rdy_in = 1'b1;
    chk($sformatf("%s grant_cycle", tag), 32'(g), 32'd1);
    chk($sformatf("%s other_port_quiet", tag), 32'(bad), 32'd0);
    if (!we || is_if) begin
      for (k = 0; k < n; k++) begin
        chk($sformatf("%s rd_addr%0d", tag, k), ra[k+1], a + 32'(k));
        chk($sformatf("%s rd_nowr%0d", tag, k), 32'(rw[k+1]), 32'd0);
      end
      chk($sformatf("%s rd_done_cycle", tag), 32'(d), 32'(n + 2));
      exp = model_read(a, n, is_if ? 1'b1 : w[2]);
      chk($sformatf("%s rdata", tag), rdat, exp);
      exp_rdata = exp;
    end else begin
      t = 1; k = 0;
      while (k < n && t < 63) begin
        blocked = zm[t] | (io & fm[t]);
        if (blocked) begin
          chk($sformatf("%s wr_stall_c%0d", tag, t), 32'(rw[t]), 32'd0);
        end else begin
          chk($sformatf("%s wr_en_c%0d", tag, t), 32'(rw[t]), 32'd1);
          chk($sformatf("%s wr_addr_c%0d", tag, t), ra[t], a + 32'(k));
          chk($sformatf("%s wr_data_c%0d", tag, t), 32'(rd[t]), 32'(8'(wd >> (8 * k))));
          k++;
        end
        t++;
      end
      chk($sformatf("%s wr_done_cycle", tag), 32'(d), 32'(t));
      chk($sformatf("%s rdata_hold", tag), rdat, exp_rdata);
    end
    exp_last_ls = !is_if;
  endtask

  logic [31:0] ra0, wd0, seq_if, seq_gap;
  logic [63:0] fm, zm;
  logic [2:0]  w0;
  bit          f0, we0, saw;
  int          gcount, last_g, n0, s0, l0, dcyc;

  initial begin
    n_cmp = 0; n_err = 0;
    exp_last_ls = 1'b0; exp_rdata = '0;
    rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; flush = 1'b0;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_width = 3'd0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_din = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset mem_a", mem_a, 32'd0);
    chk("reset mem_wr", 32'(mem_wr), 32'd0);
    chk("reset mem_dout", 32'(mem_dout), 32'd0);
    chk("reset grants", {30'd0, if_grant, ls_grant}, 32'd0);
    chk("reset dones", {30'd0, if_done, ls_done}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    next_cycle();
    rst_in = 1'b1;
    next_cycle();

    // Arbitration with both sides requesting continuously: LS first after reset.
    if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_width = 3'b010; ls_addr = 32'h40;
    gcount = 0; last_g = -1; seq_if = '0; seq_gap = '0;
    for (int c = 0; c < 100 && gcount < 6; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk_in);
      if (if_grant | ls_grant) begin
        chk($sformatf("rr winner%0d", gcount), 32'(if_grant), 32'(exp_last_ls));
        chk($sformatf("rr single%0d", gcount), 32'(if_grant & ls_grant), 32'd0);
        if (last_g >= 0) chk($sformatf("rr gap%0d", gcount), 32'(c - last_g), 32'd7);
        exp_last_ls = ls_grant;
        last_g = c;
        gcount++;
      end
    end
    chk("rr grant_count", 32'(gcount), 32'd6);
    next_cycle();
    if_req = 1'b0; ls_req = 1'b0;
    repeat (8) next_cycle();
    exp_rdata = model_read(32'h100, 4, 1'b1);
    chk("rr last_rdata", rdata, exp_rdata);

    xact(1'b1, 1'b0, 3'b010, 32'h100, '0, '0, '0, "fetch100");
    ram[8'h10] = 8'h80;
    xact(1'b0, 1'b0, 3'b000, 32'h10, '0, '0, '0, "lb");
    xact(1'b0, 1'b0, 3'b100, 32'h10, '0, '0, '0, "lbu");
    ram[8'h10] = 8'h34; ram[8'h11] = 8'h92;
    xact(1'b0, 1'b0, 3'b001, 32'h10, '0, '0, '0, "lh");
    xact(1'b0, 1'b1, 3'b010, 32'h200, 32'h11223344, '0, '0, "sw");
    xact(1'b0, 1'b1, 3'b000, 32'h30000, 32'h41, 64'h0E, '0, "sb_io");
    xact(1'b0, 1'b1, 3'b010, 32'h1FE, 32'hA1B2C3D4, '0, 64'h04, "sw_frz");
    xact(1'b0, 1'b0, 3'b010, 32'hFFFF_FFFE, '0, '0, '0, "lw_wrap");
    xact(1'b0, 1'b0, 3'b001, 32'h0003_0005, '0, 64'h1E, '0, "lh_io_full");

    // Flush in cycle 3 of a fetch with a load waiting.
    if_req = 1'b1; if_addr = 32'h80;
    @(negedge clk_in);
    next_cycle();
    if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_width = 3'b010; ls_addr = 32'h20;
    @(negedge clk_in);
    chk("flush if_grant", 32'(if_grant), 32'd1);
    saw = 1'b0;
    next_cycle();
    @(negedge clk_in); saw |= if_done;
    next_cycle(); flush = 1'b1;
    @(negedge clk_in); saw |= if_done;
    next_cycle(); flush = 1'b0;
    @(negedge clk_in); saw |= if_done;
    chk("flush idle_mem_a", mem_a, 32'd0);
    chk("flush ls_grant_c4", 32'(ls_grant), 32'd0);
    chk("flush rdata_kept", rdata, exp_rdata);
    next_cycle();
    @(negedge clk_in);
    chk("flush ls_grant_c5", 32'(ls_grant), 32'd1);
    dcyc = -1;
    for (int c = 6; c < 30 && dcyc < 0; c++) begin
      next_cycle(); ls_req = 1'b0;
      @(negedge clk_in); saw |= if_done;
      if (ls_done) begin
        dcyc = c;
        chk("flush ls_rdata", rdata, model_read(32'h20, 4, 1'b0));
      end
    end
    chk("flush ls_done_cycle", 32'(dcyc), 32'd10);
    chk("flush no_if_done", 32'(saw), 32'd0);
    exp_rdata = model_read(32'h20, 4, 1'b0);
    exp_last_ls = 1'b1;
    next_cycle();

    // Reset in the middle of a store.
    ls_req = 1'b1; ls_we = 1'b1; ls_width = 3'b010; ls_addr = 32'h60; ls_wdata = 32'hCAFEF00D;
    next_cycle(); ls_req = 1'b0;
    next_cycle(); rst_in = 1'b0;
    @(negedge clk_in);
    chk("midrst mem_wr", 32'(mem_wr), 32'd0);
    chk("midrst mem_a", mem_a, 32'd0);
    chk("midrst rdata", rdata, 32'd0);
    chk("midrst ls_done", 32'(ls_done), 32'd0);
    next_cycle(); rst_in = 1'b1;
    exp_rdata = '0; exp_last_ls = 1'b0;
    next_cycle();
    xact(1'b1, 1'b0, 3'b010, 32'h44, '0, '0, '0, "post_rst_fetch");

    for (int i = 0; i < 24; i++) begin
      f0 = ($urandom_range(3) == 0);
      we0 = f0 ? 1'b0 : 1'($urandom_range(1));
      w0 = {1'($urandom_range(1)), 2'($urandom_range(2))};
      ra0 = $urandom;
      if ($urandom_range(2) == 0) ra0[17:16] = 2'b11;
      wd0 = $urandom;
      n0 = nbytes_of(f0, w0);
      fm = '0; zm = '0;
      if ($urandom_range(1) == 1) begin
        s0 = $urandom_range(1, 3); l0 = $urandom_range(1, 3);
        for (int t = s0; t < s0 + l0; t++) fm[t] = 1'b1;
      end
      if (we0 && n0 >= 2 && $urandom_range(2) == 0) zm[$urandom_range(2, n0)] = 1'b1;
      for (int k = 0; k < 4; k++) ram[8'(ra0 + 32'(k))] = 8'($urandom);
      xact(f0, we0, w0, ra0, wd0, fm, zm, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
